clk_div_ctrl: RTL and testbench

- Four-channel programmable clock-enable generator and controller.
- Each channel divides mclk by a software-set ratio and outputs a one-cycle tick plus a near-50% divided clock level.
- Divisor changes are applied glitch-free at the terminal count. Stopping a channel drains the current period first.
- Sits between the board configuration bus and the downstream blocks that today run from fixed power-of-two taps.

---
 rtl/clk_div_ctrl.sv | 169 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Four-channel programmable clock-enable generator: per-channel tick and divided clock level.
// Optional macro CLK_DIV_SYNC_EN adds a WAIT state that phase-aligns channel 1-3 starts to channel 0.
module clk_div_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 7
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             cfg_ack,
    output logic [3:0]       tick,
    output logic [3:0]       outclk,
    output logic [3:0]       busy
);

    // state   | meaning
    // IDLE    | channel stopped, counter held at 0
    // RUN     | counting, enable bit set
    // STOP    | counting out the current period, then IDLE
    // WAIT    | enabled, holding until channel 0 terminal count (sync build only)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
`ifdef CLK_DIV_SYNC_EN
        ST_STOP = 2'd2,
        ST_WAIT = 2'd3
`else
        ST_STOP = 2'd2
`endif
    } state_t;

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W:0]   HALF_ONE = 1;

    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [CNT_W-1:0] div_q   [4];
    logic [CNT_W-1:0] div_d   [4];
    logic [CNT_W-1:0] shd_q   [4];
    logic [CNT_W-1:0] shd_d   [4];
    logic [CNT_W:0]   half    [4];
    logic [3:0]       active;
    logic [3:0]       term;
    logic             cfg_ack_q;
    logic             wr_div;
    logic             wr_en;
    logic             wr_rs;

    assign wr_div  = cfg_wr && !cfg_addr[2];
    assign wr_en   = cfg_wr && (cfg_addr == 3'd4);
    assign wr_rs   = cfg_wr && (cfg_addr == 3'd5);
    assign cfg_ack = cfg_ack_q;

    // Extra bit on the half-period threshold keeps D = 2^CNT_W-1 from wrapping.
    always_comb begin
        active = '0;
        term   = '0;
        outclk = '0;
        busy   = '0;
        half   = '{default: '0};
        for (int i = 0; i < 4; i++) begin
            active[i] = (state_q[i] == ST_RUN) || (state_q[i] == ST_STOP);
            term[i]   = active[i] && (cnt_q[i] == div_q[i]);
            half[i]   = ({1'b0, div_q[i]} + HALF_ONE) >> 1;
            outclk[i] = active[i] && ({1'b0, cnt_q[i]} >= half[i]);
            busy[i]   = (state_q[i] != ST_IDLE);
        end
    end

    assign tick = term;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        shd_d   = shd_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_div && (cfg_addr[1:0] == 2'(i))) begin
                shd_d[i] = cfg_data;
            end

            if (active[i]) begin
                if (term[i]) begin
                    cnt_d[i] = '0;
                    div_d[i] = shd_q[i];
                    if (state_q[i] == ST_STOP) begin
                        state_d[i] = ST_IDLE;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end

`ifdef CLK_DIV_SYNC_EN
            if ((state_q[i] == ST_WAIT) && term[0]) begin
                state_d[i] = ST_RUN;
                cnt_d[i]   = '0;
                div_d[i]   = shd_q[i];
            end
`endif

            // Mask writes only act on edges of the enable bit; phase is kept across STOP->RUN.
            if (wr_en) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (cfg_data[i]) begin
                            state_d[i] = ST_RUN;
                            cnt_d[i]   = '0;
                            div_d[i]   = shd_q[i];
`ifdef CLK_DIV_SYNC_EN
                            if ((i != 0) && active[0]) begin
                                state_d[i] = ST_WAIT;
                            end
`endif
                        end
                    end
                    ST_RUN: begin
                        if (!cfg_data[i]) begin
                            state_d[i] = ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (cfg_data[i]) begin
                            state_d[i] = ST_RUN;
                        end
                    end
`ifdef CLK_DIV_SYNC_EN
                    ST_WAIT: begin
                        if (!cfg_data[i]) begin
                            state_d[i] = ST_IDLE;
                        end
                    end
`endif
                    default: ;
                endcase
            end

            if (wr_rs && cfg_data[i]) begin
                state_d[i] = ST_RUN;
                cnt_d[i]   = '0;
                div_d[i]   = shd_q[i];
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                div_q[i]   <= DIV_INIT;
                shd_q[i]   <= DIV_INIT;
            end
            cfg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shd_q     <= shd_d;
            cfg_ack_q <= cfg_wr;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl; expected tick/outclk patterns are hand-derived per cycle.
// The WAIT-state section runs only when CLK_DIV_SYNC_EN is defined.
module tb_clk_div_ctrl;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ack;
    logic [3:0]  tick;
    logic [3:0]  outclk;
    logic [3:0]  busy;

    int n_chk = 0;
    int n_bad = 0;

    clk_div_ctrl dut (
        .mclk     (mclk),
        .rst      (rst),
        .cfg_wr   (cfg_wr),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_ack  (cfg_ack),
        .tick     (tick),
        .outclk   (outclk),
        .busy     (busy)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge with the write applied.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge mclk);
        cfg_wr   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge mclk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge mclk);
    endtask

    logic [15:0] tv, ov, av;

    initial begin
        @(negedge mclk);
        do_reset();
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_outclk", 32'(outclk), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(cfg_ack), 32'h0);

        // channel 0 at reset divisor 7
        wr(3'd4, 16'h0001);
        chk("ch0_busy", 32'(busy), 32'h1);
        tv = '0; ov = '0; av = '0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge mclk);
            tv[k] = tick[0];
            ov[k] = outclk[0];
            av[k] = cfg_ack;
        end
        chk("ch0_tick", 32'(tv), 32'h8080);
        chk("ch0_outclk", 32'(ov), 32'hF0F0);
        chk("ch0_ack", 32'(av), 32'h0001);

        wr(3'd6, 16'hFFFF);
        chk("ign_ack", 32'(cfg_ack), 32'h1);
        chk("ign_busy", 32'(busy), 32'h1);

        // channel 1: period 3, then D=0 mid-period
        do_reset();
        wr(3'd1, 16'd2);
        wr(3'd4, 16'h0002);
        tv = '0; ov = '0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge mclk);
            tv[k] = tick[1];
            ov[k] = outclk[1];
        end
        chk("ch1_tick3", 32'(tv), 32'h124);
        chk("ch1_outclk3", 32'(ov), 32'h1B6);
        wr(3'd1, 16'd0);
        tv = '0; ov = '0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge mclk);
            tv[k] = tick[1];
            ov[k] = outclk[1];
        end
        chk("ch1_tick0", 32'(tv), 32'h3E);
        chk("ch1_outclk0", 32'(ov), 32'h3F);

        // channel 2: D=9, stop drains, re-enable in STOP keeps phase
        do_reset();
        wr(3'd2, 16'd9);
        wr(3'd4, 16'h0004);
        idle(3);
        wr(3'd4, 16'h0000);
        chk("ch2_stop_busy", 32'(busy), 32'h4);
        idle(5);
        chk("ch2_stop_tick", 32'(tick), 32'h4);
        chk("ch2_stop_outclk", 32'(outclk), 32'h4);
        idle(1);
        chk("ch2_idle_busy", 32'(busy), 32'h0);
        chk("ch2_idle_outclk", 32'(outclk), 32'h0);
        chk("ch2_idle_tick", 32'(tick), 32'h0);
        wr(3'd4, 16'h0004);
        idle(3);
        wr(3'd4, 16'h0000);
        idle(1);
        wr(3'd4, 16'h0004);
        chk("ch2_reen_tick_early", 32'(tick), 32'h0);
        idle(3);
        chk("ch2_reen_tick", 32'(tick), 32'h4);
        idle(1);
        chk("ch2_reen_busy", 32'(busy), 32'h4);
        chk("ch2_reen_wrap", 32'({tick[2], outclk[2]}), 32'h0);
        idle(9);
        chk("ch2_run_tick", 32'(tick), 32'h4);
        idle(1);
        chk("ch2_run_busy", 32'(busy), 32'h4);

        // channel 3: restart at cnt=6
        do_reset();
        wr(3'd4, 16'h0008);
        idle(6);
        chk("ch3_pre_outclk", 32'(outclk), 32'h8);
        wr(3'd5, 16'h0008);
        tv = '0; ov = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge mclk);
            tv[k] = tick[3];
            ov[k] = outclk[3];
        end
        chk("ch3_rs_tick", 32'(tv), 32'h80);
        chk("ch3_rs_outclk", 32'(ov), 32'hF0);
        chk("ch3_rs_busy", 32'(busy), 32'h8);

        // shadow write coinciding with tick[0]
        do_reset();
        wr(3'd4, 16'h0001);
        idle(7);
        chk("sh_pre_tick", 32'(tick), 32'h1);
        wr(3'd0, 16'd3);
        tv = '0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge mclk);
            tv[k] = tick[0];
        end
        chk("sh_tick", 32'(tv), 32'h0880);

        // mid-run reset, divisors back to 7
        rst = 1'b1;
        @(negedge mclk);
        chk("mr_tick", 32'(tick), 32'h0);
        chk("mr_outclk", 32'(outclk), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        wr(3'd4, 16'h0001);
        tv = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge mclk);
            tv[k] = tick[0];
        end
        chk("mr_div_tick", 32'(tv), 32'h80);

`ifdef CLK_DIV_SYNC_EN
        // channel 1 waits for channel 0 terminal count
        do_reset();
        wr(3'd4, 16'h0001);
        idle(2);
        wr(3'd4, 16'h0003);
        chk("sy_busy", 32'(busy), 32'h3);
        chk("sy_wait_out", 32'({tick[1], outclk[1]}), 32'h0);
        idle(4);
        chk("sy_t0", 32'(tick), 32'h1);
        chk("sy_wait_busy", 32'(busy), 32'h3);
        tv = '0; ov = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge mclk);
            tv[k] = tick[1];
            ov[k] = tick[0];
        end
        chk("sy_tick1", 32'(tv), 32'h8080);
        chk("sy_tick0", 32'(ov), 32'h8080);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
